// File: rtl/cn_scratchpad.sv
// rtl/cn_scratchpad.sv - 128-bit scratchpad: priority main-loop port, host port, zero-fill engine
// Optional feature: define CN_SCRATCHPAD_PARITY_EN for per-word even parity with sticky error.
module cn_scratchpad #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ml_rden,
    input  logic                  ml_wren,
    input  logic [ADDR_WIDTH-1:0] ml_addr,
    input  logic [127:0]          ml_wrdata,
    output logic [127:0]          ml_rddata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [127:0]          host_wrdata,
    output logic [127:0]          host_rddata,
    output logic                  host_ack,
    input  logic                  ctrl_clear,
    output logic                  sts_clearing,
    output logic                  sts_clear_done,
    output logic                  sts_conflict,
    output logic                  sts_parity_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    localparam logic [1:0] H_IDLE = 2'd0;
    localparam logic [1:0] H_RD   = 2'd1;
    localparam logic [1:0] H_ACK  = 2'd2;

    localparam logic [0:0] C_IDLE = 1'b0;
    localparam logic [0:0] C_RUN  = 1'b1;

    logic [127:0]          mem [DEPTH];

    logic [1:0]            h_state;
    logic [ADDR_WIDTH-1:0] h_addr_q;
    logic [0:0]            c_state;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic                  clear_q;

    logic                  ml_busy;
    logic                  host_accept;
    logic                  fill_en;
    logic                  clear_rise;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [127:0]          wr_data;

    assign ml_busy     = ml_rden | ml_wren;
    assign host_accept = (h_state == H_IDLE) && host_req && !ml_busy && (c_state == C_IDLE);
    assign fill_en     = (c_state == C_RUN) && !ml_busy;
    assign clear_rise  = ctrl_clear && !clear_q;

    assign host_ack     = (h_state == H_ACK);
    assign sts_clearing = (c_state == C_RUN);

    // Single write port; host and fill never overlap because host accept waits for the fill.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ml_addr;
        wr_data = ml_wrdata;
        if (ml_wren) begin
            wr_en = 1'b1;
        end else if (host_accept && host_we) begin
            wr_en   = 1'b1;
            wr_addr = host_addr;
            wr_data = host_wrdata;
        end else if (fill_en) begin
            wr_en   = 1'b1;
            wr_addr = fill_cnt;
            wr_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A conflicting read is dropped so the previous read data stays visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ml_rddata <= '0;
        end else if (ml_rden && !ml_wren) begin
            ml_rddata <= mem[ml_addr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sts_conflict <= 1'b0;
        end else if (ml_rden && ml_wren) begin
            sts_conflict <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_state     <= H_IDLE;
            h_addr_q    <= '0;
            host_rddata <= '0;
        end else begin
            case (h_state)
                H_IDLE: begin
                    if (host_accept) begin
                        h_addr_q <= host_addr;
                        h_state  <= host_we ? H_ACK : H_RD;
                    end
                end
                H_RD: begin
                    host_rddata <= mem[h_addr_q];
                    h_state     <= H_ACK;
                end
                H_ACK:   h_state <= H_IDLE;
                default: h_state <= H_IDLE;
            endcase
        end
    end

    // Fill stops after the last word instead of wrapping back to address 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_state        <= C_IDLE;
            fill_cnt       <= '0;
            clear_q        <= 1'b0;
            sts_clear_done <= 1'b0;
        end else begin
            clear_q <= ctrl_clear;
            case (c_state)
                C_IDLE: begin
                    if (clear_rise) begin
                        c_state        <= C_RUN;
                        fill_cnt       <= '0;
                        sts_clear_done <= 1'b0;
                    end
                end
                C_RUN: begin
                    if (fill_en) begin
                        if (fill_cnt == LAST_ADDR) begin
                            c_state        <= C_IDLE;
                            sts_clear_done <= 1'b1;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                default: c_state <= C_IDLE;
            endcase
        end
    end

`ifdef CN_SCRATCHPAD_PARITY_EN
    logic par_mem [DEPTH];
    logic ml_perr;
    logic host_perr;
    logic perr_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_mem[wr_addr] <= ^wr_data;
        end
    end

    assign ml_perr   = ml_rden && !ml_wren && ((^mem[ml_addr]) != par_mem[ml_addr]);
    assign host_perr = (h_state == H_RD) && ((^mem[h_addr_q]) != par_mem[h_addr_q]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perr_q <= 1'b0;
        end else if (ml_perr || host_perr) begin
            perr_q <= 1'b1;
        end
    end

    assign sts_parity_err = perr_q;
`else
    assign sts_parity_err = 1'b0;
`endif

endmodule

// File: doc/cn_scratchpad.md
CN_SCRATCHPAD -- requirements
Module: cn_scratchpad

Interface
REQ-001 Parameter ADDR_WIDTH, default 17: word-address width; depth 2^ADDR_WIDTH words of 128 bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 ml_rden  input  1  main-loop read strobe.
REQ-005 ml_wren  input  1  main-loop write strobe.
REQ-006 ml_addr  input  ADDR_WIDTH  main-loop word address.
REQ-007 ml_wrdata  input  128  main-loop write data.
REQ-008 ml_rddata  output  128  main-loop read data, registered.
REQ-009 host_req  input  1  host access request, held until host_ack.
REQ-010 host_we  input  1  host write (1) / read (0), stable while host_req is high.
REQ-011 host_addr  input  ADDR_WIDTH  host word address.
REQ-012 host_wrdata  input  128  host write data.
REQ-013 host_rddata  output  128  host read data, valid while host_ack is high.
REQ-014 host_ack  output  1  one-cycle completion pulse.
REQ-015 ctrl_clear  input  1  level; a rising edge starts a zero-fill.
REQ-016 sts_clearing  output  1  zero-fill in progress.
REQ-017 sts_clear_done  output  1  sticky; set when a zero-fill completes.
REQ-018 sts_conflict  output  1  sticky; ml_rden and ml_wren were asserted together.
REQ-019 sts_parity_err  output  1  sticky parity error (see Configuration).

Function
REQ-020 ml port SHALL have absolute priority and never stall: each ml access is performed in the cycle its strobe is sampled.
REQ-021 ml read: ml_rddata SHALL equal mem[ml_addr] one cycle after ml_rden, and SHALL hold until the next ml read.
REQ-022 ml write: mem[ml_addr] SHALL be updated at the edge sampling ml_wren; a read of the same address in the next cycle SHALL return the new data.
REQ-023 ml_rden and ml_wren both high: the write SHALL be performed, the read dropped (ml_rddata held), and sts_conflict set.
REQ-024 Host FSM states: H_IDLE, H_RD, H_ACK.
REQ-025 A host access SHALL be accepted in any cycle with host_req high, no ml strobe, sts_clearing low and state H_IDLE.
REQ-026 Accepted host write: H_IDLE -> H_ACK; mem updated at the accept edge; host_ack high in the following cycle.
REQ-027 Accepted host read: H_IDLE -> H_RD -> H_ACK; host_rddata captured in H_RD; host_ack high in H_ACK; H_ACK -> H_IDLE.
REQ-028 A pending host_req SHALL wait, with no time-out, while ml strobes or clearing block it; no request SHALL be lost or duplicated.
REQ-029 Clear FSM states: C_IDLE, C_RUN. A ctrl_clear rising edge in C_IDLE SHALL enter C_RUN, clear sts_clear_done, and reset the fill counter to 0.
REQ-030 C_RUN: write zero to mem[counter] and increment the counter in every cycle without an ml strobe; ml-strobe cycles SHALL pause the fill.
REQ-031 After the write to address 2^ADDR_WIDTH-1, the FSM SHALL return to C_IDLE and set sts_clear_done in the same edge; the counter SHALL NOT wrap to rewrite address 0.
REQ-032 ctrl_clear edges during C_RUN SHALL be ignored.
REQ-033 A host access already in H_RD or H_ACK when a clear starts SHALL complete normally.

Reset
REQ-034 Asserting reset_n low SHALL immediately force: ml_rddata=0, host_rddata=0, host_ack=0, sts_clearing=0, sts_clear_done=0, sts_conflict=0, sts_parity_err=0, both FSMs to idle, fill counter=0.
REQ-035 Memory contents SHALL NOT be reset; a reset during C_RUN leaves the array partially zeroed and sts_clear_done=0.

Configuration
REQ-036 Macro CN_SCRATCHPAD_PARITY_EN defined: each word SHALL store an even-parity bit computed on write (ml, host, or fill).
REQ-037 With the macro defined, every ml or host read SHALL check parity and set sts_parity_err on mismatch; read data SHALL still be returned.
REQ-038 Macro CN_SCRATCHPAD_PARITY_EN undefined: no parity storage; sts_parity_err SHALL be tied to 0.

Verification
REQ-039 ml write addr 0x00010 data 0x0123..EF, then ml read 0x00010 in the next cycle -> ml_rddata=0x0123..EF one cycle after the read.
REQ-040 Host read requested while ml strobes are high for 5 consecutive cycles -> host_ack arrives exactly 2 cycles after the first strobe-free cycle, with correct data.
REQ-041 ctrl_clear pulse with ADDR_WIDTH=4 and no ml traffic -> sts_clearing high for 16 cycles, then sts_clear_done=1 and all 16 words read back 0.
REQ-042 ml_rden=ml_wren=1 at addr 0x3 with data 0xAA -> mem[3]=0xAA, ml_rddata unchanged, sts_conflict=1.
REQ-043 reset_n pulsed low after 7 fill writes (ADDR_WIDTH=4) -> all outputs at reset values; words 0-6 read 0, word 7 keeps prior data.
REQ-044 With CN_SCRATCHPAD_PARITY_EN defined, force-flip one stored bit of word 5, then host read word 5 -> sts_parity_err=1; without the macro -> sts_parity_err=0.
